// File: rtl/mod_exp.sv
// Modular exponentiation: result = base^exponent mod modulus.
// Left-to-right square-and-always-multiply over all WIDTH exponent bits,
// each modular multiply done bit-serially (shift-add-subtract, MSB first),
// so the latency is fixed for any legal operand set.
module mod_exp #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    FIN
  } state_t;

  state_t state, state_next;

  // Latched operands; the running job never looks at the input ports again.
  logic [WIDTH-1:0] base_reg;
  logic [WIDTH-1:0] exp_reg;
  logic [WIDTH-1:0] mod_reg;

  // Accumulator R, partial product P and the shifting multiplier copy.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CW-1:0]    step_cnt;
  logic [CW-1:0]    bit_cnt;
  logic             err_flag;

  logic             step_last;
  logic             bit_last;
  logic             illegal;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] p_dbl;
  logic [WIDTH+1:0] p_s1;
  logic [WIDTH+1:0] p_add;
  logic [WIDTH-1:0] mm_out;
  logic [WIDTH-1:0] r_commit;
  logic [WIDTH-1:0] r_init;

  assign step_last = (step_cnt == CW'(WIDTH - 1));
  assign bit_last  = (bit_cnt == CW'(WIDTH - 1));
  assign illegal   = (mod_reg == '0) || (base_reg >= mod_reg);
  assign r_init    = (mod_reg == WIDTH'(1)) ? '0 : WIDTH'(1);

  // One shift-add-subtract step of the running modular multiply.
  // P < M on entry keeps every intermediate below 2M, so two extra bits suffice.
  always_comb begin
    mcand  = (state == MUL) ? base_reg : r_reg;
    m_ext  = {2'b00, mod_reg};
    p_dbl  = {1'b0, p_reg, 1'b0};
    p_s1   = (p_dbl >= m_ext) ? (p_dbl - m_ext) : p_dbl;
    p_add  = p_s1 + (mplier_reg[WIDTH-1] ? {2'b00, mcand} : '0);
    mm_out = (p_add >= m_ext) ? WIDTH'(p_add - m_ext) : WIDTH'(p_add);
    // The multiply is always performed; only a 1 bit lets it replace R.
    r_commit = exp_reg[WIDTH-1] ? mm_out : r_reg;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = illegal ? FIN : SQR;
      SQR:  if (step_last) state_next = MUL;
      MUL:  if (step_last) state_next = bit_last ? FIN : SQR;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg   <= '0;
      exp_reg    <= '0;
      mod_reg    <= '0;
      r_reg      <= '0;
      p_reg      <= '0;
      mplier_reg <= '0;
      step_cnt   <= '0;
      bit_cnt    <= '0;
      err_flag   <= 1'b0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_reg <= base;
            exp_reg  <= exponent;
            mod_reg  <= modulus;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          err_flag   <= illegal;
          r_reg      <= r_init;
          mplier_reg <= r_init;
          p_reg      <= '0;
          step_cnt   <= '0;
          bit_cnt    <= '0;
        end
        SQR: begin
          if (step_last) begin
            // R = R*R mod M is complete; next multiply is R*base.
            r_reg      <= mm_out;
            mplier_reg <= mm_out;
            p_reg      <= '0;
            step_cnt   <= '0;
          end else begin
            p_reg      <= mm_out;
            mplier_reg <= mplier_reg << 1;
            step_cnt   <= step_cnt + CW'(1);
          end
        end
        MUL: begin
          if (step_last) begin
            r_reg      <= r_commit;
            mplier_reg <= r_commit;
            p_reg      <= '0;
            step_cnt   <= '0;
            exp_reg    <= exp_reg << 1;
            bit_cnt    <= bit_cnt + CW'(1);
          end else begin
            p_reg      <= mm_out;
            mplier_reg <= mplier_reg << 1;
            step_cnt   <= step_cnt + CW'(1);
          end
        end
        FIN: begin
          result <= err_flag ? '0 : r_reg;
          err    <= err_flag;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp.sv
// Directed bench for mod_exp at WIDTH=16 with hand-computed expectations.
module tb_mod_exp;

  localparam int W       = 16;
  localparam int LAT_OK  = 2 * W * W + 2;  // 514
  localparam int LAT_ERR = 2;
  localparam int BOUND   = 2000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         err;

  int errors;
  int checks;
  int lat;
  int spurious;

  mod_exp #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Present operands with start high for exactly one sampling edge.
  task automatic start_job(input int b, input int e, input int m);
    base     = W'(b);
    exponent = W'(e);
    modulus  = W'(m);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after the sampling edge until done is seen (bounded).
  task automatic wait_done(input int c0, output int n);
    int c;
    c = c0;
    n = -1;
    while (c < BOUND) begin
      @(posedge clk);
      #1 c++;
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic job(input string tag, input int b, input int e, input int m,
                     input int exp_r, input int exp_e, input int exp_lat);
    start_job(b, e, m);
    wait_done(0, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_result"}, int'(result), exp_r);
    check({tag, "_err"}, int'(err), exp_e);
    $display("job %s: base=%0d exp=%0d mod=%0d -> result=%0d err=%0d lat=%0d",
             tag, b, e, m, result, err, lat);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    modulus  = '0;

    #12;
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_no_done", int'(done), 0);

    // Basic job, plus busy / single-cycle done.
    start_job(4, 13, 497);
    check("busy_after_accept", int'(busy), 1);
    wait_done(0, lat);
    check("j1_lat", lat, LAT_OK);
    check("j1_result", int'(result), 445);
    check("j1_err", int'(err), 0);
    check("j1_busy_at_done", int'(busy), 0);
    $display("job j1: 4^13 mod 497 -> result=%0d err=%0d lat=%0d", result, err, lat);
    // Back-to-back: start during the done cycle.
    start_job(2790, 2753, 3233);
    check("done_one_cycle", int'(done), 0);
    wait_done(0, lat);
    check("rsa_lat", lat, LAT_OK);
    check("rsa_result", int'(result), 65);
    check("rsa_err", int'(err), 0);
    $display("job rsa: 2790^2753 mod 3233 -> result=%0d lat=%0d", result, lat);

    job("exp0", 5, 0, 7, 1, 0, LAT_OK);
    job("mod1", 0, 5, 1, 0, 0, LAT_OK);
    job("mod0", 3, 5, 0, 0, 1, LAT_ERR);
    job("base_ge_mod", 9, 3, 7, 0, 1, LAT_ERR);
    job("small", 3, 4, 11, 4, 0, LAT_OK);      // 81 mod 11 = 4
    job("base_eq_mod", 7, 2, 7, 0, 1, LAT_ERR);

    // Reset in the middle of a job.
    @(negedge clk);
    start_job(4, 13, 497);
    repeat (199) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", int'(result), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    $display("reset asserted mid-job: result=%0d busy=%0d done=%0d", result, busy, done);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    spurious = 0;
    repeat (LAT_OK + 20) begin
      @(posedge clk);
      #1 if (done !== 1'b0) spurious++;
    end
    check("midrst_no_done", spurious, 0);
    job("after_rst", 4, 13, 497, 445, 0, LAT_OK);

    // Start re-pulsed with different operands at cycle 10 is ignored.
    start_job(4, 13, 497);
    repeat (9) @(posedge clk);
    #1;
    base     = W'(2);
    exponent = W'(3);
    modulus  = W'(11);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(10, lat);
    check("repulse_lat", lat, LAT_OK);
    check("repulse_result", int'(result), 445);
    check("repulse_err", int'(err), 0);
    $display("job repulse: result=%0d err=%0d lat=%0d", result, err, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_exp.md
MOD_EXP -- requirements
Module: mod_exp

Interface
REQ-001 SHALL have parameter WIDTH, default 512, meaning the operand/result bit width (verification also runs WIDTH=16).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port base  input  WIDTH  message/ciphertext operand c.
REQ-006 SHALL have port exponent  input  WIDTH  exponent (e.g. d mod (p-1)).
REQ-007 SHALL have port modulus  input  WIDTH  modulus (p, q or n).
REQ-008 SHALL have port result  output  WIDTH  base^exponent mod modulus, registered, held until the next accepted start.
REQ-009 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL have port err  output  1  registered; valid with done; high for an illegal operand set.

Function
REQ-012 SHALL use the FSM states IDLE, LOAD, SQR, MUL, FIN, with transitions IDLE->LOAD on start, LOAD->SQR (or LOAD->FIN on error), SQR->MUL after WIDTH cycles, MUL->SQR after WIDTH cycles while exponent bits remain, MUL->FIN after the LSB, and FIN->IDLE unconditionally.
REQ-013 SHALL latch base, exponent and modulus on the accepting edge; input changes afterwards have no effect on the running job.
REQ-014 SHALL ignore start while busy, and in FIN.
REQ-015 SHALL flag err in LOAD when modulus==0 or base>=modulus, skipping SQR/MUL; result=0, err=1.
REQ-016 SHALL initialise the accumulator R in LOAD to 0 if modulus==1, else 1.
REQ-017 SHALL scan all WIDTH exponent bits MSB-first, with no leading-zero skip, so that latency is constant.
REQ-018 SHALL, per exponent bit, perform SQR (R=R*R mod M) and then always perform MUL (T=R*base mod M), committing R=T only when the bit is 1.
REQ-019 SHALL implement each modular multiply as interleaved shift-add-subtract, one multiplier bit per cycle, MSB-first: P=2P, then P=P-M if P>=M, then P=P+(bit?multiplicand:0), then P=P-M if P>=M; with WIDTH+2-bit internal precision; no multiplier or divider primitives.
REQ-020 SHALL keep every intermediate strictly below modulus on completion of each cycle's step.
REQ-021 SHALL assert done exactly 2*WIDTH*WIDTH+2 cycles after the start-sampling edge for legal operands, and 2 cycles after it for err.
REQ-022 SHALL update result and err on the same edge that raises done.
REQ-023 SHALL accept a start asserted on the cycle after done, giving back-to-back jobs with no dead cycle beyond IDLE.
REQ-024 SHALL produce result=1 (or 0 if modulus==1) when exponent==0.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, result=0, busy=0, done=0, err=0 and all datapath registers to 0, independent of clk.
REQ-026 SHALL abort an in-flight job when reset is asserted mid-operation; no done is generated for it, and the first start after release is processed normally.
REQ-027 SHALL leave the module in IDLE after reset release, with no spurious done.

Verification (WIDTH=16)
REQ-028 SHALL verify base=4, exponent=13, modulus=497 -> result=445, err=0, done exactly 514 cycles after start.
REQ-029 SHALL verify base=2790, exponent=2753, modulus=3233 -> result=65 (RSA round-trip of m=65, e=17).
REQ-030 SHALL verify base=5, exponent=0, modulus=7 -> result=1; then base=0, exponent=5, modulus=1 -> result=0, err=0.
REQ-031 SHALL verify modulus=0 or base=9 with modulus=7 -> err=1, result=0, done 2 cycles after start.
REQ-032 SHALL verify that rst_n pulsed low at cycle 200 of a 4^13 mod 497 job produces outputs 0 immediately and no done; a new start then gives 445 after 514 cycles.
REQ-033 SHALL verify that start re-pulsed with different operands at cycle 10 of a job is ignored, and the original result is produced.
